// File: rtl/ccu_pkg.sv
// Shared types, cycle constants and the one-hot helper for the CCU run sequencer.
package ccu_pkg;

  typedef enum logic {IDLE, WINDOW} main_state_t;
  typedef enum logic [1:0] {PIDLE, DRIVE, GAP, PDONE} prog_state_t;

  localparam int MIN_INTERVAL = 8;
  localparam int PREPROG_CYC  = 0;
  localparam int PROG_CYC     = 2;
  localparam int MAX_CU       = 256;

  // Address 0 maps to the most significant coupling unit.
  function automatic logic [MAX_CU-1:0] onehot_msb_first(input int addr, input int n_cu);
    logic [MAX_CU-1:0] v;
    v = '0;
    if (addr >= 0 && addr < n_cu) v = MAX_CU'(1) << (n_cu - 1 - addr);
    return v;
  endfunction

endpackage

// File: rtl/ccu_run_sequencer_if.sv
// Host/array-facing signal bundle of the CCU run sequencer.
interface ccu_run_sequencer_if #(
  parameter int N_CU    = 50,
  parameter int LANG_W  = 16,
  parameter int CNT_W   = 8,
  parameter int SCH_LEN = 128
);
  logic               i_soft_reset;
  logic               i_load;
  logic               i_run;
  logic               i_rerun;
  logic [CNT_W-1:0]   i_total_run;
  logic [CNT_W-1:0]   i_total_rerun;
  logic [CNT_W-1:0]   i_run_interval;
  logic [1:0]         i_fix_langevin_sel;
  logic [SCH_LEN-1:0] i_anneal_sch;
  logic [CNT_W-1:0]   o_run_counter;
  logic [CNT_W-1:0]   o_rerun_counter;
  logic               o_pre_prog_ic;
  logic               o_prog_ic;
  logic [N_CU-1:0]    o_cu_prog_ena;
  logic               o_ccii_ena;
  logic               o_spin_fix_ena;
  logic               o_anneal_sch_bit;
  logic               o_langevin_ena;
  logic [LANG_W-1:0]  o_langevin_res_bank;
  logic               o_read_out_ena;
  logic               o_read_out_valid;
  logic               o_final_run;
  logic               o_loading_done;
  logic               o_busy;

  modport master (
    output i_soft_reset, i_load, i_run, i_rerun, i_total_run, i_total_rerun,
           i_run_interval, i_fix_langevin_sel, i_anneal_sch,
    input  o_run_counter, o_rerun_counter, o_pre_prog_ic, o_prog_ic, o_cu_prog_ena,
           o_ccii_ena, o_spin_fix_ena, o_anneal_sch_bit, o_langevin_ena,
           o_langevin_res_bank, o_read_out_ena, o_read_out_valid, o_final_run,
           o_loading_done, o_busy
  );

  modport slave (
    input  i_soft_reset, i_load, i_run, i_rerun, i_total_run, i_total_rerun,
           i_run_interval, i_fix_langevin_sel, i_anneal_sch,
    output o_run_counter, o_rerun_counter, o_pre_prog_ic, o_prog_ic, o_cu_prog_ena,
           o_ccii_ena, o_spin_fix_ena, o_anneal_sch_bit, o_langevin_ena,
           o_langevin_res_bank, o_read_out_ena, o_read_out_valid, o_final_run,
           o_loading_done, o_busy
  );
endinterface

// File: rtl/ccu_cu_prog_seq.sv
// Coupling-unit programming sequencer: strobes each CU one-hot, MSB first, with a gap cycle between.
module ccu_cu_prog_seq
  import ccu_pkg::*;
#(
  parameter int N_CU = 50
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            prog_ic,
  input  logic            load,
  output logic [N_CU-1:0] cu_prog_ena,
  output logic            loading_done
);
  localparam int ADDR_W = (N_CU < 2) ? 1 : $clog2(N_CU + 1);

  prog_state_t       state;
  logic [ADDR_W-1:0] addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PIDLE;
      addr         <= '0;
      cu_prog_ena  <= '0;
      loading_done <= 1'b0;
    end else begin
      case (state)
        PIDLE: if (prog_ic && load) begin
          state       <= DRIVE;
          addr        <= '0;
          cu_prog_ena <= N_CU'(onehot_msb_first(0, N_CU));
        end
        DRIVE: begin
          state       <= GAP;
          cu_prog_ena <= '0;
        end
        GAP: if (int'(addr) == N_CU - 1) begin
          state        <= PDONE;
          loading_done <= 1'b1;
        end else begin
          state       <= DRIVE;
          addr        <= addr + ADDR_W'(1);
          cu_prog_ena <= N_CU'(onehot_msb_first(int'(addr) + 1, N_CU));
        end
        PDONE: loading_done <= 1'b1;
        default: state <= PIDLE;
      endcase
    end
  end

endmodule

// File: rtl/ccu_run_sequencer.sv
// Central control unit: sequences RUN/RERUN windows, CU programming and Langevin stepping.
// Optional macro CCU_AUTO_RERUN_EN: after each RUN window, self-issue RERUNs until the budget is used.
module ccu_run_sequencer
  import ccu_pkg::*;
#(
  parameter int N_CU     = 50,
  parameter int LANG_W   = 16,
  parameter int CNT_W    = 8,
  parameter int SCH_LEN  = 128,
  parameter int LEAD_CYC = 3,
  parameter int TAIL_CYC = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  ccu_run_sequencer_if.slave bus
);
  localparam int IDX_W = (SCH_LEN < 2) ? 1 : $clog2(SCH_LEN);

  logic run_q, rerun_q, soft_q;
  logic run_edge, rerun_edge, rst_any;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run_q   <= 1'b0;
      rerun_q <= 1'b0;
      soft_q  <= 1'b0;
    end else begin
      run_q   <= bus.i_run;
      rerun_q <= bus.i_rerun;
      soft_q  <= bus.i_soft_reset;
    end
  end

  assign run_edge   = bus.i_run & ~run_q;
  assign rerun_edge = bus.i_rerun & ~rerun_q;
  assign rst_any    = i_rst | (bus.i_soft_reset & ~soft_q);

  main_state_t      state;
  logic [CNT_W-1:0] cyc, t_win, interval, run_cnt, rerun_cnt;
  logic [IDX_W-1:0] sch_idx, idx_cur;
  logic             run_win, auto_pend;
  logic             idle, start_run, start_rerun, starting, win_end, active_next;
  logic             lang_on, fix_on, run_next;
  logic [CNT_W-1:0] t_run, t_rerun, t_new;
  int               nc, nt, lang_end;

  assign idle        = (state == IDLE);
  assign start_run   = idle && !auto_pend && run_edge && (run_cnt < bus.i_total_run);
  assign start_rerun = idle && !start_run && (rerun_cnt < bus.i_total_rerun) &&
                       (interval != '0) && (auto_pend || (rerun_edge && !run_edge));
  assign starting    = start_run || start_rerun;
  assign t_run   = (int'(bus.i_run_interval) < MIN_INTERVAL) ? CNT_W'(MIN_INTERVAL) : bus.i_run_interval;
  assign t_rerun = (interval == '1) ? interval : interval + CNT_W'(1);
  assign t_new   = start_run ? t_run : t_rerun;
  assign win_end = (state == WINDOW) && (cyc == t_win - CNT_W'(1));

  // Outputs are registered, so everything is decoded from the index of the upcoming cycle.
  assign active_next = starting || ((state == WINDOW) && !win_end);
  assign nc          = starting ? 0 : int'(cyc) + 1;
  assign nt          = starting ? int'(t_new) : int'(t_win);
  assign run_next    = starting ? start_run : run_win;
  assign lang_end    = (LEAD_CYC + LANG_W < nt - TAIL_CYC) ? LEAD_CYC + LANG_W : nt - TAIL_CYC;
  assign lang_on     = active_next && bus.i_fix_langevin_sel[0] && nc >= LEAD_CYC && nc < lang_end;
  assign fix_on      = active_next && bus.i_fix_langevin_sel[1] && nc >= LEAD_CYC && nc < nt - TAIL_CYC;
  assign idx_cur     = starting ? '0 : sch_idx;

  always_ff @(posedge i_clk) begin
    if (rst_any) begin
      state                   <= IDLE;
      cyc                     <= '0;
      t_win                   <= '0;
      interval                <= '0;
      run_cnt                 <= '0;
      rerun_cnt               <= '0;
      run_win                 <= 1'b0;
      sch_idx                 <= '0;
      bus.o_busy              <= 1'b0;
      bus.o_ccii_ena          <= 1'b0;
      bus.o_pre_prog_ic       <= 1'b0;
      bus.o_prog_ic           <= 1'b0;
      bus.o_langevin_ena      <= 1'b0;
      bus.o_langevin_res_bank <= '0;
      bus.o_spin_fix_ena      <= 1'b0;
      bus.o_anneal_sch_bit    <= 1'b0;
      bus.o_read_out_ena      <= 1'b0;
      bus.o_read_out_valid    <= 1'b0;
    end else begin
      if (starting) begin
        state    <= WINDOW;
        t_win    <= t_new;
        interval <= t_new;
        run_win  <= start_run;
        if (start_run) run_cnt   <= run_cnt + CNT_W'(1);
        else           rerun_cnt <= rerun_cnt + CNT_W'(1);
      end else if (win_end) begin
        state <= IDLE;
      end
      cyc     <= active_next ? CNT_W'(nc) : '0;
      sch_idx <= (fix_on && idx_cur != IDX_W'(SCH_LEN - 1)) ? idx_cur + IDX_W'(1) : idx_cur;
      bus.o_busy              <= active_next;
      bus.o_ccii_ena          <= active_next;
      bus.o_pre_prog_ic       <= active_next && run_next && nc == PREPROG_CYC;
      bus.o_prog_ic           <= active_next && run_next && nc == PROG_CYC;
      bus.o_langevin_ena      <= lang_on;
      bus.o_langevin_res_bank <= lang_on ? LANG_W'(1) << (nc - LEAD_CYC) : '0;
      bus.o_spin_fix_ena      <= fix_on;
      bus.o_anneal_sch_bit    <= fix_on && bus.i_anneal_sch[idx_cur];
      bus.o_read_out_ena      <= active_next && nc == nt - 2;
      bus.o_read_out_valid    <= active_next && nc == nt - 1;
    end
  end

`ifdef CCU_AUTO_RERUN_EN
  logic auto_win;

  // Auto chain continues only from RUN windows or from windows it issued itself.
  always_ff @(posedge i_clk) begin
    if (rst_any) begin
      auto_pend <= 1'b0;
      auto_win  <= 1'b0;
    end else begin
      if (starting) auto_win <= start_rerun && auto_pend;
      if (start_rerun)
        auto_pend <= 1'b0;
      else if (win_end && (run_win || auto_win))
        auto_pend <= rerun_cnt < bus.i_total_rerun;
    end
  end
`else
  assign auto_pend = 1'b0;
`endif

  logic [CNT_W:0] done_sum, total_sum;

  assign done_sum            = {1'b0, run_cnt} + {1'b0, rerun_cnt};
  assign total_sum           = {1'b0, bus.i_total_run} + {1'b0, bus.i_total_rerun};
  assign bus.o_final_run     = (total_sum != '0) && (done_sum == total_sum);
  assign bus.o_run_counter   = run_cnt;
  assign bus.o_rerun_counter = rerun_cnt;

  ccu_cu_prog_seq #(.N_CU(N_CU)) u_cu_prog (
    .clk          (i_clk),
    .rst          (rst_any),
    .prog_ic      (bus.o_prog_ic),
    .load         (bus.i_load),
    .cu_prog_ena  (bus.o_cu_prog_ena),
    .loading_done (bus.o_loading_done)
  );

endmodule

// File: tb/tb_ccu_run_sequencer.sv
// Scoreboard bench for ccu_run_sequencer: stimulus queues expected windows, a monitor checks them.
module tb_ccu_run_sequencer;
  localparam int N_CU = 50, LANG_W = 16, CNT_W = 8, SCH_LEN = 128, LEAD = 3, TAIL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ccu_run_sequencer_if #(.N_CU(N_CU), .LANG_W(LANG_W), .CNT_W(CNT_W), .SCH_LEN(SCH_LEN)) bus ();

  ccu_run_sequencer #(.N_CU(N_CU), .LANG_W(LANG_W), .CNT_W(CNT_W), .SCH_LEN(SCH_LEN),
                      .LEAD_CYC(LEAD), .TAIL_CYC(TAIL)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    bit               is_run;
    int               t;
    bit [1:0]         sel;
    bit [SCH_LEN-1:0] sch;
    int               run_cnt;
    int               rerun_cnt;
    bit               fin;
    int               abort_at;
  } win_t;

  win_t exp_q[$];
  int checks = 0, errors = 0, windows_seen = 0;
  int m_run = 0, m_rerun = 0, m_intv = 0, tot_run = 0, tot_rerun = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [24:0] act_vec();
    return {bus.o_ccii_ena, bus.o_pre_prog_ic, bus.o_prog_ic, bus.o_langevin_ena,
            bus.o_langevin_res_bank, bus.o_spin_fix_ena, bus.o_anneal_sch_bit,
            bus.o_read_out_ena, bus.o_read_out_valid, bus.o_busy};
  endfunction

  function automatic logic [92:0] full_vec();
    return {act_vec(), bus.o_cu_prog_ena, bus.o_loading_done, bus.o_run_counter,
            bus.o_rerun_counter, bus.o_final_run};
  endfunction

  // Expected window outputs straight from the cycle-index rules.
  function automatic logic [24:0] exp_vec(input win_t w, input int c);
    int lend, idx;
    logic lang, fix, sbit;
    logic [LANG_W-1:0] bank;
    lend = (LEAD + LANG_W < w.t - TAIL) ? LEAD + LANG_W : w.t - TAIL;
    lang = w.sel[0] && c >= LEAD && c < lend;
    fix  = w.sel[1] && c >= LEAD && c < w.t - TAIL;
    bank = lang ? LANG_W'(1) << (c - LEAD) : '0;
    idx  = (c - LEAD > SCH_LEN - 1) ? SCH_LEN - 1 : c - LEAD;
    sbit = fix ? w.sch[7'(idx)] : 1'b0;
    return {1'b1, w.is_run && c == 0, w.is_run && c == 2, lang, bank, fix, sbit,
            c == w.t - 2, c == w.t - 1, 1'b1};
  endfunction

  initial begin : monitor
    win_t w;
    int c;
    bit in_win, stray;
    in_win = 0;
    stray = 0;
    c = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_win = 0;
      end else if (stray) begin
        if (!bus.o_busy) stray = 0;
      end else if (!in_win) begin
        if (bus.o_busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_window", 128'(bus.o_busy), 128'(0));
            stray = 1;
          end else begin
            w = exp_q.pop_front();
            c = 0;
            in_win = 1;
            check("win_c0", 128'(act_vec()), 128'(exp_vec(w, 0)));
          end
        end
      end else begin
        c++;
        if (w.abort_at >= 0 && c == w.abort_at + 1) begin
          check("abort_all_zero", 128'(full_vec()), 128'(0));
          in_win = 0;
          windows_seen++;
        end else if (c < w.t) begin
          check($sformatf("win_t%0d_c%0d", w.t, c), 128'(act_vec()), 128'(exp_vec(w, c)));
        end else begin
          check("win_end_idle", 128'(act_vec()), 128'(0));
          check("run_counter", 128'(bus.o_run_counter), 128'(w.run_cnt));
          check("rerun_counter", 128'(bus.o_rerun_counter), 128'(w.rerun_cnt));
          check("final_run", 128'(bus.o_final_run), 128'(w.fin));
          in_win = 0;
          windows_seen++;
        end
      end
    end
  end

  task automatic set_totals(input int a, input int b);
    tot_run = a;
    tot_rerun = b;
    bus.i_total_run = CNT_W'(a);
    bus.i_total_rerun = CNT_W'(b);
  endtask

  task automatic do_reset();
    bus.i_run = 0;
    bus.i_rerun = 0;
    bus.i_soft_reset = 0;
    rst = 1;
    tick(2);
    rst = 0;
    m_run = 0;
    m_rerun = 0;
    m_intv = 0;
    tick(1);
  endtask

  task automatic wait_windows(input int target, input int budget);
    int n = 0;
    while (windows_seen < target && n < budget) begin
      tick(1);
      n++;
    end
    check("window_complete", 128'(windows_seen), 128'(target));
  endtask

  task automatic request(input bit r, input bit rr, input int abort_at);
    win_t w;
    bit acc;
    int iv, target;
    acc = 0;
    iv = int'(bus.i_run_interval);
    w.sel = bus.i_fix_langevin_sel;
    w.sch = bus.i_anneal_sch;
    w.abort_at = abort_at;
    w.is_run = 0;
    w.t = 0;
    if (r) begin
      if (m_run < tot_run) begin
        acc = 1;
        w.is_run = 1;
        w.t = (iv < 8) ? 8 : iv;
        m_run++;
        m_intv = w.t;
      end
    end else if (rr) begin
      if (m_rerun < tot_rerun && m_intv != 0) begin
        acc = 1;
        w.t = (m_intv >= 255) ? 255 : m_intv + 1;
        m_rerun++;
        m_intv = w.t;
      end
    end
    w.run_cnt = m_run;
    w.rerun_cnt = m_rerun;
    w.fin = (m_run + m_rerun == tot_run + tot_rerun) && (tot_run + tot_rerun != 0);
    target = windows_seen + (acc ? 1 : 0);
    if (acc) exp_q.push_back(w);
    bus.i_run = r;
    bus.i_rerun = rr;
    tick(1);
    check(acc ? "accept_latency" : "reject_idle", 128'(bus.o_busy), 128'(acc));
    bus.i_run = 0;
    bus.i_rerun = 0;
    if (acc && abort_at >= 0) begin
      tick(abort_at);
      bus.i_soft_reset = 1;
      tick(1);
      bus.i_soft_reset = 0;
      m_run = 0;
      m_rerun = 0;
      m_intv = 0;
      wait_windows(target, 10);
    end else if (acc) begin
      wait_windows(target, w.t + 20);
    end else begin
      tick(6);
    end
  endtask

  task automatic cu_check();
    int n = 0;
    logic [N_CU-1:0] e;
    while (!bus.o_prog_ic && n < 60) begin
      tick(1);
      n++;
    end
    check("prog_ic_seen", 128'(bus.o_prog_ic), 128'(1));
    for (int k = 0; k < 102; k++) begin
      tick(1);
      e = (k < 100 && k % 2 == 0) ? N_CU'(1) << (N_CU - 1 - k / 2) : '0;
      check($sformatf("cu_k%0d", k), 128'({bus.o_cu_prog_ena, bus.o_loading_done}),
            128'({e, k >= 100}));
    end
  endtask

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stimulus
    int kind;
    bus.i_soft_reset = 0;
    bus.i_load = 0;
    bus.i_run = 0;
    bus.i_rerun = 0;
    bus.i_run_interval = '0;
    bus.i_fix_langevin_sel = 2'b00;
    bus.i_anneal_sch = '0;
    set_totals(0, 0);
    tick(3);
    check("reset_held", 128'(full_vec()), 128'(0));
    do_reset();
    check("reset_released", 128'(full_vec()), 128'(0));

    // Basic RUN, T=20, both features on
    set_totals(10, 10);
    bus.i_run_interval = 8'd20;
    bus.i_fix_langevin_sel = 2'b11;
    bus.i_anneal_sch = {$urandom, $urandom, $urandom, $urandom};
    request(1, 0, -1);

    // CU programming triggered after prog_ic with load high
    bus.i_load = 1;
    bus.i_run_interval = 8'd12;
    bus.i_fix_langevin_sel = 2'($urandom);
    fork
      request(1, 0, -1);
      cu_check();
    join
    bus.i_load = 1;
    request(1, 0, -1);
    check("cu_done_sticky", 128'({bus.o_cu_prog_ena, bus.o_loading_done}), 128'({50'd0, 1'b1}));
    bus.i_load = 0;

    // RUN then three RERUNs, fourth ignored
    set_totals(1, 3);
    do_reset();
    bus.i_run_interval = 8'd10;
    bus.i_fix_langevin_sel = 2'b11;
    request(1, 0, -1);
    repeat (3) request(0, 1, -1);
    request(0, 1, -1);
    check("final_run_after_reruns", 128'(bus.o_final_run), 128'(1));

    // Short interval clamps to 8; schedule bit 0 of ...0101
    set_totals(4, 4);
    do_reset();
    bus.i_run_interval = 8'd3;
    bus.i_anneal_sch = {$urandom, $urandom, $urandom, $urandom};
    bus.i_anneal_sch[3:0] = 4'b0101;
    request(1, 0, -1);

    // Simultaneous edges, then RERUN with no prior RUN
    set_totals(5, 5);
    do_reset();
    bus.i_run_interval = 8'($urandom_range(8, 30));
    request(1, 1, -1);
    do_reset();
    request(0, 1, -1);
    check("rerun_without_run", 128'(bus.o_rerun_counter), 128'(0));

    // Soft reset in the middle of a T=30 window
    bus.i_run_interval = 8'd30;
    bus.i_fix_langevin_sel = 2'b11;
    request(1, 0, 5);

    // Interval saturation
    set_totals(1, 3);
    do_reset();
    bus.i_run_interval = 8'd254;
    request(1, 0, -1);
    request(0, 1, -1);
    request(0, 1, -1);

    // Randomised traffic
    set_totals($urandom_range(2, 6), $urandom_range(2, 6));
    do_reset();
    repeat (25) begin
      kind = $urandom_range(0, 3);
      bus.i_fix_langevin_sel = 2'($urandom);
      bus.i_run_interval = 8'($urandom_range(0, 40));
      bus.i_anneal_sch = {$urandom, $urandom, $urandom, $urandom};
      bus.i_load = 1'($urandom);
      case (kind)
        0: request(1, 0, -1);
        3: if (m_run < tot_run) request(1, 1, -1); else request(0, 1, -1);
        default: request(0, 1, -1);
      endcase
    end

    tick(4);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
